// File: rtl/wave_pkg.sv
// wave_pkg: FSM states and sample-to-word assembly shared by wave_packetizer.
package wave_pkg;
   localparam int WORD_MAX = 64;
   typedef enum logic [2:0] {
      IDLE, FETCH, STREAM, TRAILER
`ifdef WAVE_PACKETIZER_CKSUM_EN
      , CKSUM
`endif
   } state_t;
   function automatic logic [WORD_MAX-1:0] mk_word(input logic [WORD_MAX-1:0] s, input int sw, input logic sx);
      logic [WORD_MAX-1:0] m;
      m = {WORD_MAX{1'b1}} << sw;
      return (sx && s[sw-1]) ? (s | m) : (s & ~m);
   endfunction
endpackage

// File: rtl/wave_skid_buf.sv
// wave_skid_buf: 2-entry valid/ready buffer; head register drives the output and holds while stalled.
module wave_skid_buf #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   cnt
);
   logic [W-1:0] m1;
   logic pop;
   assign out_valid = cnt != 2'd0;
   assign pop = out_valid && out_ready;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt <= '0;
         out_data <= '0;
         m1 <= '0;
      end else begin
         cnt <= cnt + {1'b0, in_valid} - {1'b0, pop};
         if (pop || cnt == 2'd0) out_data <= cnt == 2'd2 ? m1 : in_data;
         if (in_valid && cnt != 2'd0) m1 <= in_data;
      end
endmodule

// File: rtl/wave_packetizer.sv
// wave_packetizer: streams per-channel RAM waveforms as one valid/ready packet closed by a wave-number trailer.
// Define WAVE_PACKETIZER_CKSUM_EN to append a 16-bit wrapping checksum word after the trailer.
module wave_packetizer
   import wave_pkg::*;
#(
   parameter  int NUM_CH   = 2,
   parameter  int DEPTH    = 1000,
   parameter  int SAMPLE_W = 14,
   parameter  int OUT_W    = 16,
   parameter  int SIGN_EXT = 0,
   localparam int ADDR_W   = $clog2(DEPTH),
   localparam int CH_W     = NUM_CH > 2 ? $clog2(NUM_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [15:0]                wavenum,
   output logic                       busy,
   output logic                       overrun,
   output logic                       rd_en,
   output logic [ADDR_W-1:0]          rd_addr,
   input  logic [NUM_CH*SAMPLE_W-1:0] rd_data,
   output logic [OUT_W-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_sop,
   output logic                       out_eop,
   output logic [15:0]                lastwavenum
);
   state_t st;
   logic [CH_W-1:0] ch, rd_ch;
   logic [ADDR_W-1:0] idx;
   logic [15:0] wn;
   logic rd_done, rd_pend, rd_sop, bv, pop, last;
   logic [1:0] cnt, occ;
   logic [OUT_W+1:0] bq;
   logic [OUT_W-1:0] word;
   logic [SAMPLE_W-1:0] smp;
   assign rd_addr = idx;
   assign busy = st != IDLE;
   assign last = ch == CH_W'(NUM_CH - 1) && idx == ADDR_W'(DEPTH - 1);
   assign pop = bv && out_ready;
   // a read lands in the buffer two edges later; only current pop is known, so count it as credit
   assign occ = cnt + {1'b0, rd_pend};
   assign rd_en = st == FETCH || (st == STREAM && !rd_done && (occ < 2'd2 || (occ == 2'd2 && pop)));
   assign smp = rd_data[int'(rd_ch)*SAMPLE_W +: SAMPLE_W];
   assign word = OUT_W'(mk_word(WORD_MAX'(smp), SAMPLE_W, SIGN_EXT != 0));
   wave_skid_buf #(.W(OUT_W + 2)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_pend),
      .in_data   ({rd_sop, 1'b0, word}),
      .out_valid (bv),
      .out_ready (out_ready),
      .out_data  (bq),
      .cnt       (cnt)
   );
`ifdef WAVE_PACKETIZER_CKSUM_EN
   logic [15:0] sum;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sum <= '0;
      else sum <= st == IDLE ? '0 : (out_valid && out_ready) ? sum + out_data[15:0] : sum;
`endif
   always_comb begin
      out_valid = bv || st == TRAILER;
      out_data = st == TRAILER ? OUT_W'(wn) : bq[OUT_W-1:0];
      out_sop = bv && bq[OUT_W+1];
`ifdef WAVE_PACKETIZER_CKSUM_EN
      out_valid = out_valid || st == CKSUM;
      out_data = st == CKSUM ? OUT_W'(sum) : out_data;
      out_eop = bv ? bq[OUT_W] : st == CKSUM;
`else
      out_eop = bv ? bq[OUT_W] : st == TRAILER;
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st <= IDLE;
         ch <= '0;
         idx <= '0;
         wn <= '0;
         lastwavenum <= '0;
         overrun <= 1'b0;
         rd_done <= 1'b0;
         rd_pend <= 1'b0;
         rd_ch <= '0;
         rd_sop <= 1'b0;
      end else begin
         overrun <= start && st != IDLE;
         rd_pend <= rd_en;
         rd_ch <= ch;
         rd_sop <= ch == '0 && idx == '0;
         if (rd_en) begin
            rd_done <= last;
            ch <= last ? '0 : ch + CH_W'(idx == ADDR_W'(DEPTH - 1));
            idx <= idx == ADDR_W'(DEPTH - 1) ? '0 : idx + 1'b1;
         end
         case (st)
            IDLE: if (start) begin
               st <= FETCH;
               wn <= wavenum;
               ch <= '0;
               idx <= '0;
               rd_done <= 1'b0;
            end
            FETCH: st <= STREAM;
            STREAM: if (rd_done && !rd_pend && (cnt == 2'd0 || (cnt == 2'd1 && pop))) st <= TRAILER;
`ifdef WAVE_PACKETIZER_CKSUM_EN
            TRAILER: if (out_ready) st <= CKSUM;
            CKSUM: if (out_ready) begin
               st <= IDLE;
               lastwavenum <= wn;
            end
`else
            TRAILER: if (out_ready) begin
               st <= IDLE;
               lastwavenum <= wn;
            end
`endif
            default: st <= IDLE;
         endcase
      end
endmodule

// File: doc/wave_packetizer.md
# wave_packetizer

Streams captured ADC waveforms out of per-channel sample RAMs as one word stream with valid/ready flow control, for the Ethernet payload builder. One packet carries every sample of every channel in order, followed by a trailer word holding the wave number. Parametrised in channel count, depth and sample width, and tolerant of downstream backpressure. Sits between the waveform capture RAMs and the UDP frame assembler.

## Interface
Parameters:
- NUM_CH, 2: number of ADC channels per packet.
- DEPTH, 1000: samples per channel.
- SAMPLE_W, 14: ADC sample width.
- OUT_W, 16: stream word width; must be ≥ SAMPLE_W and ≥ 16.
- SIGN_EXT, 0: 0 zero-extends samples to OUT_W; 1 sign-extends them.

Derived values: ADDR_W = $clog2(DEPTH) and CH_W = max(1, $clog2(NUM_CH)).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request one packet; sampled only in IDLE.
- wavenum  in  16  wave number; latched on an accepted start.
- busy  out  1  high from accepted start until trailer (or checksum) handshake.
- overrun  out  1  one-cycle pulse when start is asserted while busy.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  sample index 0..DEPTH-1.
- rd_data  in  NUM_CH*SAMPLE_W  channel c on bits [c*SAMPLE_W +: SAMPLE_W]; synchronous RAM, 1-cycle latency.
- out_data  out  OUT_W  stream word.
- out_valid  out  1  word valid.
- out_ready  in  1  downstream ready; transfer when out_valid && out_ready.
- out_sop / out_eop  out  1  first word / last word of the packet.
- lastwavenum  out  16  wavenum of the last completed packet.

## Operation
- FSM states: IDLE, FETCH, STREAM, TRAILER, CKSUM (CKSUM exists only with the macro).
- IDLE -> FETCH on start: latch wavenum, clear ch=0 and idx=0, raise busy.
- FETCH: issue the first read, then go to STREAM.
- STREAM: issue reads in channel-major order (ch 0 idx 0..DEPTH-1, then ch 1, ...). Each read result enters a 2-entry skid buffer.
- Reads are issued only while the skid buffer has space. This guarantees no word is ever dropped or duplicated under any out_ready pattern.
- After the last read (ch=NUM_CH-1, idx=DEPTH-1) and a drained buffer, go to TRAILER.
- TRAILER: out_data = zero-extended latched wavenum, out_eop=1 (unless the macro is set). On handshake, lastwavenum <= latched wavenum and the FSM returns to IDLE (or goes to CKSUM).
- Packet length: NUM_CH*DEPTH + 1 words.
- out_sop is high only on word 0 (ch 0, idx 0).
- Index wrap: idx rolls to 0 and ch increments. The ch/idx counters never exceed their ranges.
- The data path never changes out_data while out_valid && !out_ready (AXI-stream rule).
- start in a non-IDLE state: ignored, and overrun pulses. A start on the same cycle the FSM returns to IDLE is also ignored; start is accepted only while in IDLE.

## Timing
- Reset values: busy=0, overrun=0, rd_en=0, rd_addr=0, out_data=0, out_valid=0, out_sop=0, out_eop=0, lastwavenum=0, state=IDLE.
- Reset mid-packet aborts immediately. No eop is emitted, and lastwavenum is unchanged from its reset value.
- Latency: start accepted at cycle 0 -> first out_valid at cycle 3.
- With out_ready held high: one word per cycle, packet ends at cycle 3 + NUM_CH*DEPTH.
- Stall recovery: after out_ready rises, the buffered word is presented the same cycle and throughput resumes at 1/cycle with no bubble.

## Configuration
- Macro: WAVE_PACKETIZER_CKSUM_EN.
- Defined: a CKSUM word follows the trailer. It is the 16-bit wrapping sum of all preceding OUT_W words (lower 16 bits of each). The trailer then has out_eop=0, the checksum word has out_eop=1, and lastwavenum updates on the checksum handshake. Packet length becomes NUM_CH*DEPTH + 2.
- Undefined: no CKSUM state and no accumulator logic.

## Structure
- Shared package wave_pkg holds the FSM state enum and the word-assembly function (sample -> OUT_W with zero/sign extension per SIGN_EXT).
- One sub-module: wave_skid_buf (2-entry valid/ready skid buffer, parameter W = OUT_W+2 carrying sop/eop).

## Test plan
- NUM_CH=2, DEPTH=4, RAM holding ch0={1,2,3,4} and ch1={5,6,7,8}, wavenum=0x0042, out_ready=1 -> stream 1,2,3,4,5,6,7,8,0x0042. sop on word 1, eop on 0x0042, lastwavenum=0x0042 after the handshake, first valid at cycle 3.
- Same setup with out_ready toggling 1,0,0,1 repeating -> an identical word sequence, with no drops or duplicates and out_data stable whenever stalled.
- SIGN_EXT=1 with sample 14'h2000 -> word 16'hE000. SIGN_EXT=0 with the same sample -> word 16'h2000.
- start pulsed at word 3 of a packet -> overrun pulses once, the packet is unaffected, and no second packet follows.
- rst_n asserted after word 5 -> all outputs return to reset values within the same cycle, and a new start produces a complete packet.
- WAVE_PACKETIZER_CKSUM_EN with the first scenario -> trailer eop=0, then checksum 0x0066 (36 + 0x42) with eop=1.
